// File: rtl/signal_rom_scheduler.sv
// Shares one 1-cycle synchronous signal ROM among 4 playback channels, each with its own
// sample-rate divider, through a round-robin read scheduler and a 3-stage return pipeline.
module signal_rom_scheduler #(
   parameter int unsigned PTR_WIDTH  = 6,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3:0]                ch_en_i,
   input  logic [4*DIV_WIDTH-1:0]    period_i,
   output logic [ADDR_WIDTH-1:0]     rom_addr_o,
   input  logic [DATA_WIDTH-1:0]     rom_data_i,
   output logic [4*DATA_WIDTH-1:0]   sample_o,
   output logic [3:0]                sample_vld_o,
   output logic [3:0]                overrun_o
);

   logic [DIV_WIDTH-1:0] r_timer [4];
   logic [PTR_WIDTH-1:0] r_ptr   [4];
   logic [3:0]           r_pend;
   logic [1:0]           r_last;
   logic                 r_a_vld;
   logic [1:0]           r_a_ch;
   logic                 r_b_vld;
   logic [1:0]           r_b_ch;

   logic [3:0]           w_tick;
   logic [3:0]           w_req;
   logic [3:0]           w_gnt;
   logic                 w_gnt_vld;
   logic [1:0]           w_gnt_ch;
   logic [1:0]           w_cand;

   always_comb begin
      w_tick = '0;
      for (int unsigned n = 0; n < 4; n++) begin
         w_tick[n] = ch_en_i[n] && (r_timer[n] == period_i[n*DIV_WIDTH +: DIV_WIDTH]);
      end
   end

   assign w_req = r_pend & ch_en_i;

   // Search starts one past the last grant; i==4 wraps back to the last grant itself.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_ch  = r_last;
      w_cand    = r_last;
      w_gnt     = '0;
      for (int unsigned i = 1; i <= 4; i++) begin
         w_cand = r_last + 2'(i);
         if (!w_gnt_vld && w_req[w_cand]) begin
            w_gnt_vld = 1'b1;
            w_gnt_ch  = w_cand;
         end
      end
      if (w_gnt_vld) begin
         w_gnt[w_gnt_ch] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned n = 0; n < 4; n++) begin
            r_timer[n] <= '0;
            r_ptr[n]   <= '0;
         end
         r_pend    <= '0;
         overrun_o <= '0;
      end else begin
         for (int unsigned n = 0; n < 4; n++) begin
            if (!ch_en_i[n]) begin
               r_timer[n] <= '0;
               r_ptr[n]   <= '0;
               r_pend[n]  <= 1'b0;
            end else begin
               r_timer[n] <= w_tick[n] ? '0 : r_timer[n] + DIV_WIDTH'(1);
               // A tick merges into an outstanding request; only an unserved one overruns.
               r_pend[n]  <= w_tick[n] | (r_pend[n] & ~w_gnt[n]);
               if (w_gnt[n]) begin
                  r_ptr[n] <= r_ptr[n] + PTR_WIDTH'(1);
               end
               if (w_tick[n] && r_pend[n] && !w_gnt[n]) begin
                  overrun_o[n] <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr_o   <= '0;
         r_last       <= 2'd3;
         r_a_vld      <= 1'b0;
         r_a_ch       <= '0;
         r_b_vld      <= 1'b0;
         r_b_ch       <= '0;
         sample_o     <= '0;
         sample_vld_o <= '0;
      end else begin
         if (w_gnt_vld) begin
            rom_addr_o <= {w_gnt_ch, r_ptr[w_gnt_ch]};
            r_last     <= w_gnt_ch;
         end
         r_a_vld <= w_gnt_vld;
         r_a_ch  <= w_gnt_ch;
         // Reads for a channel disabled at any point in flight are squashed stage by stage.
         r_b_vld <= r_a_vld && ch_en_i[r_a_ch];
         r_b_ch  <= r_a_ch;

         sample_vld_o <= '0;
         for (int unsigned n = 0; n < 4; n++) begin
            if (!ch_en_i[n]) begin
               sample_o[n*DATA_WIDTH +: DATA_WIDTH] <= '0;
            end
         end
         if (r_b_vld && ch_en_i[r_b_ch]) begin
            sample_o[r_b_ch*DATA_WIDTH +: DATA_WIDTH] <= rom_data_i;
            sample_vld_o[r_b_ch]                      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_signal_rom_scheduler.sv
// Directed bench for signal_rom_scheduler with a behavioural synchronous ROM.
module tb_signal_rom_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  ch_en = '0;
   logic [63:0] period = '0;
   logic [7:0]  rom_addr;
   logic [0:0]  rom_data;
   logic [3:0]  sample;
   logic [3:0]  vld;
   logic [3:0]  ovr;
   logic [0:0]  mem [256];

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] t3_addr   [9] = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h80, 8'hC0, 8'h01, 8'h41, 8'h81};
   logic [3:0] t3_vld    [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
   logic [3:0] t3_sample [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h3, 4'hB, 4'hA};

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= mem[rom_addr];

   signal_rom_scheduler #(
      .PTR_WIDTH  (6),
      .ADDR_WIDTH (8),
      .DATA_WIDTH (1),
      .DIV_WIDTH  (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ch_en_i      (ch_en),
      .period_i     (period),
      .rom_addr_o   (rom_addr),
      .rom_data_i   (rom_data),
      .sample_o     (sample),
      .sample_vld_o (vld),
      .overrun_o    (ovr)
   );

   task automatic step(input int unsigned n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      ch_en = '0;
      step(2);
      rst   = 1'b0;
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 1'b0;
      mem[8'h00] = 1'b1;
      mem[8'h01] = 1'b0;
      mem[8'h02] = 1'b1;
      mem[8'h40] = 1'b1;
      mem[8'hC0] = 1'b1;
      mem[8'hBF] = 1'b1;

      // 1: reset values, then idle with all channels disabled
      rst = 1'b1;
      step(2);
      chk("rst_addr", rom_addr, 0);
      chk("rst_sample", sample, 0);
      chk("rst_vld", vld, 0);
      chk("rst_ovr", ovr, 0);
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("idle_addr", rom_addr, 0);
         chk("idle_vld", vld, 0);
      end

      // 2: ch0 alone, period 3
      do_reset();
      period = 64'd3;
      ch_en  = 4'b0001;
      for (int k = 1; k <= 15; k++) begin
         step();
         chk("t2_vld", vld, (k == 7 || k == 11 || k == 15) ? 4'b0001 : 4'b0000);
         if (k == 5)  chk("t2_addr0", rom_addr, 8'h00);
         if (k == 9)  chk("t2_addr1", rom_addr, 8'h01);
         if (k == 13) chk("t2_addr2", rom_addr, 8'h02);
         if (k == 7)  chk("t2_smp0", sample, 4'b0001);
         if (k == 11) chk("t2_smp1", sample, 4'b0000);
         if (k == 15) chk("t2_smp2", sample, 4'b0001);
      end
      ch_en = 4'b0000;
      step();
      chk("t2_dis_sample", sample, 0);
      chk("t2_ovr", ovr, 0);

      // 3: all channels, period 0, round robin and overrun
      do_reset();
      period = '0;
      ch_en  = 4'hF;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("t3_vld", vld, t3_vld[k]);
         if (k >= 2) chk("t3_addr", rom_addr, t3_addr[k]);
         if (k >= 4) chk("t3_sample", sample, t3_sample[k]);
         chk("t3_ovr", ovr, (k == 1) ? 4'h0 : (k == 2) ? 4'hE : 4'hF);
      end

      // 4: ch2 pointer wrap
      do_reset();
      period = '0;
      ch_en  = 4'b0100;
      for (int k = 1; k <= 68; k++) begin
         step();
         if (k == 65) chk("t4_addr_bf", rom_addr, 8'hBF);
         if (k == 66) chk("t4_addr_80", rom_addr, 8'h80);
         if (k == 67) chk("t4_addr_81", rom_addr, 8'h81);
         if (k == 66) chk("t4_smp_be", sample, 4'b0000);
         if (k == 67) chk("t4_smp_bf", sample, 4'b0100);
         if (k == 67) chk("t4_vld", vld, 4'b0100);
         if (k == 68) chk("t4_smp_80", sample, 4'b0000);
      end
      chk("t4_ovr", ovr, 0);

      // 5: ch1 disabled mid-flight, then re-enabled
      do_reset();
      period = 64'h0000_0000_0003_0000;
      ch_en  = 4'b0010;
      step(5);
      chk("t5_addr_first", rom_addr, 8'h40);
      ch_en = 4'b0000;
      for (int k = 6; k <= 10; k++) begin
         step();
         chk("t5_kill_vld", vld, 0);
         chk("t5_kill_sample", sample, 0);
      end
      ch_en = 4'b0010;
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k <= 4) chk("t5_re_vld_idle", vld, 0);
         if (k == 5) chk("t5_re_addr", rom_addr, 8'h40);
         if (k == 7) chk("t5_re_vld", vld, 4'b0010);
         if (k == 7) chk("t5_re_sample", sample, 4'b0010);
      end

      // 6: async reset during back-to-back reads on ch0/ch3
      do_reset();
      period = '0;
      ch_en  = 4'b1001;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k == 2) chk("t6_addr0", rom_addr, 8'h00);
         if (k == 3) chk("t6_addr1", rom_addr, 8'hC0);
         if (k == 4) chk("t6_vld4", vld, 4'b0001);
         if (k == 5) chk("t6_vld5", vld, 4'b1000);
         if (k == 5) chk("t6_smp5", sample, 4'b1001);
         if (k == 6) chk("t6_smp6", sample, 4'b1000);
         if (k == 6) chk("t6_ovr", ovr, 4'b1001);
      end
      rst = 1'b1;
      #1;
      chk("t6_rst_addr", rom_addr, 0);
      chk("t6_rst_sample", sample, 0);
      chk("t6_rst_vld", vld, 0);
      chk("t6_rst_ovr", ovr, 0);
      for (int k = 1; k <= 2; k++) begin
         step();
         chk("t6_hold_vld", vld, 0);
      end
      rst = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k <= 3) chk("t6_rel_vld_idle", vld, 0);
         if (k == 2) chk("t6_rel_addr0", rom_addr, 8'h00);
         if (k == 3) chk("t6_rel_addr1", rom_addr, 8'hC0);
         if (k == 4) chk("t6_rel_vld", vld, 4'b0001);
         if (k == 4) chk("t6_rel_sample", sample, 4'b0001);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
